// File: rtl/unload.sv
// Result unload stage: captures the multiplier product on done, holds it for the
// consumer until ack, and flags any done that arrives while a result is pending.
module unload #(
  parameter int DW   = 16,
  parameter int DW_2 = 2 * DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            done,
  input  logic [DW_2-1:0] product,
  input  logic            ack,
  input  logic            clr_ovr,
  output logic [DW_2-1:0] result,
  output logic            valid,
  output logic            ready,
  output logic            overrun,
  output logic [7:0]      res_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW_2-1:0] result_q, result_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      res_cnt_q, res_cnt_d;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    res_cnt_d = res_cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (done) begin
          result_d = product;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d   = IDLE;
          res_cnt_d = res_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A done that finds the slot occupied is dropped; setting beats clearing.
    if (state_q == HOLD && done) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      overrun_q <= 1'b0;
      res_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      overrun_q <= overrun_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign valid   = (state_q == HOLD);
  assign ready   = (state_q == IDLE);
  assign result  = result_q;
  assign overrun = overrun_q;
  assign res_cnt = res_cnt_q;

endmodule
